// File: rtl/booth_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_pkg
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - state_e    : controller states IDLE / RUN / DONE
//   - sel_e      : Booth magnitude select (zero, 1*M, 2*M); the sign travels
//                  separately as a NEG flag
//   - BOOTH_ITER : iteration-count derivation, two multiplier bits per step
//   - cla8       : the 8-bit carry-lookahead adder block used in the datapath
// -----------------------------------------------------------------------------
`ifndef BOOTH_ITER
`define BOOTH_ITER(w) ((w) / 2)
`endif

package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_TWO  = 2'd2
  } sel_e;

  // 8-bit carry-lookahead block: every carry is formed directly from the
  // generate/propagate terms and the block carry-in, not rippled.
  // Returns {carry_out, sum[7:0]}.
  function automatic logic [8:0] cla8(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       t;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      // carry-in propagated through every bit 0..i
      t = cin;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      // generate at bit j propagated through bits j+1..i
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[8], p ^ c[7:0]};
  endfunction

endpackage

// File: rtl/booth_mult_seq_recode.sv
// -----------------------------------------------------------------------------
// booth_recode
// Radix-4 modified-Booth recoder, purely combinational.
//   win_i [2:0] : multiplier window {b[2i+1], b[2i], b[2i-1]}
//   sel_o [1:0] : magnitude select (SEL_ZERO / SEL_ONE / SEL_TWO)
//   neg_o       : subtract the selected multiple instead of adding it
// -----------------------------------------------------------------------------
module booth_recode
  import booth_mult_seq_pkg::*;
(
  input  logic [2:0] win_i,
  output logic [1:0] sel_o,
  output logic       neg_o
);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    sel_o = SEL_ZERO;
    neg_o = 1'b0;
    unique case (win_i)
      3'b001, 3'b010: sel_o = SEL_ONE;
      3'b011:         sel_o = SEL_TWO;
      3'b100: begin
        sel_o = SEL_TWO;
        neg_o = 1'b1;
      end
      3'b101, 3'b110: begin
        sel_o = SEL_ONE;
        neg_o = 1'b1;
      end
      default: ;  // 000 / 111: zero term, never negated
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-4 modified-Booth signed multiplier. One partial product is
// added per clock into the upper part of a shifting product register; after
// WIDTH/2 steps the low WIDTH bits and a signed-overflow flag are published
// together with a one-cycle ready pulse.
//
// Parameters
//   WIDTH           operand/result width, even and >= 8 (default 32)
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   ctrl_mult       start pulse; restarts any operation in flight
//   data_a/data_b   signed multiplicand / multiplier, sampled only at start
//   data_result     low WIDTH bits of a*b, held until the next completion
//   data_exception  product does not fit in WIDTH signed bits
//   data_resultRDY  one-cycle completion pulse
//   busy            high while iterating
// Build option
//   MULT_ZERO_SKIP_EN : a zero operand at start goes straight to DONE with a
//                       zero result and no overflow.
// -----------------------------------------------------------------------------
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int ITER  = `BOOTH_ITER(WIDTH);
  localparam int PW    = 2 * WIDTH + 3;       // {acc[WIDTH+1:0], b, guard}
  localparam int AW    = WIDTH + 2;           // accumulator width
  localparam int NBLK  = WIDTH / 8;           // full CLA blocks
  localparam int LO    = NBLK * 8;
  localparam int TOPW  = AW - LO;             // sign-extension slice, 2..8 bits
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [PW-1:0]      p_q, p_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;

  // ---------------- Booth term selection ----------------
  logic [1:0]    sel;
  logic          neg;
  logic [AW-1:0] mag, term, acc, sum;
  logic [PW-1:0] p_shift;

  booth_recode u_recode (
    .win_i (p_q[2:0]),
    .sel_o (sel),
    .neg_o (neg)
  );

  always_comb begin
    mag = '0;
    unique case (sel)
      SEL_ONE: mag = {{2{m_q[WIDTH-1]}}, m_q};
      SEL_TWO: mag = {m_q[WIDTH-1], m_q, 1'b0};
      default: ;
    endcase
    // subtraction = add of the inverted term with carry-in 1
    term = neg ? ~mag : mag;
  end

  assign acc = p_q[PW-1:WIDTH+1];

  // ---------------- accumulator adder: CLA blocks + top slice ----------------
  logic [NBLK:0] carry;
  assign carry[0] = neg;

  for (genvar g = 0; g < NBLK; g++) begin : g_cla
    logic [8:0] r;
    assign r            = cla8(acc[g*8 +: 8], term[g*8 +: 8], carry[g]);
    assign sum[g*8 +: 8] = r[7:0];
    assign carry[g+1]   = r[8];
  end

  // carry out of the top slice is dropped: the accumulator is wide enough
  assign sum[AW-1:LO] = acc[AW-1:LO] + term[AW-1:LO] + TOPW'(carry[NBLK]);

  // add into the upper bits, then arithmetic shift right by two
  assign p_shift = {{2{sum[AW-1]}}, sum, p_q[WIDTH:2]};

  // ---------------- controller / next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (ctrl_mult) begin
      // a start always wins, aborting whatever is in flight
      m_d     = data_a;
      p_d     = {{AW{1'b0}}, data_b, 1'b0};
      cnt_d   = '0;
      state_d = ST_RUN;
`ifdef MULT_ZERO_SKIP_EN
      if (data_a == '0 || data_b == '0) begin
        state_d = ST_DONE;
        res_d   = '0;
        exc_d   = 1'b0;
      end
`endif
    end else begin
      unique case (state_q)
        ST_RUN: begin
          p_d   = p_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            // product[2W-1:0] now sits in p[2W:1]
            res_d   = p_shift[WIDTH:1];
            exc_d   = p_shift[2*WIDTH:WIDTH+1] != {WIDTH{p_shift[WIDTH]}};
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  // NOTE: datapath registers are reset as well, so every output reads 0 straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking, so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q == ST_RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Self-checking bench for booth_mult_seq (default build, WIDTH = 32).
// A reference model computes each product with plain 64-bit arithmetic and
// predicts the busy window and ready cycle from the start edge; a compare
// process checks all outputs against it on every falling edge. Directed runs
// pin the model with hand-computed literals; the bulk is random operands with
// random restarts.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  localparam int W    = 32;
  localparam int ITER = W / 2;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         ctrl_mult = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_mult      (ctrl_mult),
    .data_a         (data_a),
    .data_b         (data_b),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  bit           pend    = 1'b0;   // written only by the driver
  int           k_start = 0;      // edge count at which the start was sampled
  logic [W-1:0] pend_res = '0;
  logic         pend_exc = 1'b0;
  logic [W-1:0] hold_res = '0;    // written only by the compare process
  logic         hold_exc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[W-1:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin : cmp
    int   d;
    logic exp_busy, exp_rdy;
    d        = cyc - k_start;
    exp_busy = pend && (d >= 0) && (d < ITER);
    exp_rdy  = pend && (d == ITER);
    if (!reset_n) begin
      hold_res = '0;
      hold_exc = 1'b0;
    end else if (exp_rdy) begin
      hold_res = pend_res;
      hold_exc = pend_exc;
    end
    check("busy",   busy,           exp_busy);
    check("ready",  data_resultRDY, exp_rdy);
    check("result", data_result,    hold_res);
    check("exc",    data_exception, hold_exc);
  end

  // ---------------- driver helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    data_a    = a;
    data_b    = b;
    ctrl_mult = 1'b1;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    k_start   = cyc;
    pend      = 1'b1;
    model(a, b, pend_res, pend_exc);
    // operands are don't-care outside the start edge
    data_a = $urandom;
    data_b = $urandom;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 0; i < ITER + 4; i++) begin
      if (data_resultRDY) begin
        lat = cyc - k_start;
        break;
      end
      idle(1);
    end
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic e);
    logic [W-1:0] mr;
    logic         me;
    int           lat;
    model(a, b, mr, me);
    check({name, "_model_res"}, mr, r);
    check({name, "_model_exc"}, me, e);
    start(a, b);
    wait_rdy(lat);
    check({name, "_latency"}, lat, ITER);
    check({name, "_res"}, data_result, r);
    check({name, "_exc"}, data_exception, e);
    idle(1);
  endtask

  logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [W-1:0] pick_operand();
    logic [15:0] h;
    case ($urandom_range(0, 3))
      0: begin
        h = 16'($urandom);
        return {{16{h[15]}}, h};
      end
      1:       return corners[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  initial begin : drive
    int pulses;
    int gap;
    // reset state
    #2;
    check("rst_result", data_result, 0);
    check("rst_exc",    data_exception, 0);
    check("rst_ready",  data_resultRDY, 0);
    check("rst_busy",   busy, 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    idle(1);

    // hand-computed products
    run_directed("7x6",       32'd7,          32'd6,          32'd42,         1'b0);
    run_directed("m3x5",      32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0);
    run_directed("minxm1",    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
    run_directed("2p16sq",    32'h0001_0000,  32'h0001_0000,  32'h0,          1'b1);
    run_directed("7fffx10001",32'h0000_7FFF,  32'h0001_0001,  32'h7FFF_7FFF,  1'b0);
    run_directed("zeroxb",    32'h0,          32'd12345,      32'h0,          1'b0);

    // restart mid-operation: only the second operation completes
    start(32'd3, 32'd3);
    idle(4);
    start(32'd4, 32'd4);
    pulses = 0;
    for (int i = 0; i < ITER + 4; i++) begin
      if (data_resultRDY) begin
        pulses++;
        check("abort_res", data_result, 32'd16);
        check("abort_lat", cyc - k_start, ITER);
      end
      idle(1);
    end
    check("abort_pulses", pulses, 1);

    // asynchronous reset mid-operation
    start(32'd11, 32'd13);
    idle(8);
    #1 reset_n = 1'b0;
    pend = 1'b0;
    #1;
    check("midrst_result", data_result, 0);
    check("midrst_exc",    data_exception, 0);
    check("midrst_ready",  data_resultRDY, 0);
    check("midrst_busy",   busy, 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    idle(ITER + 2);
    run_directed("after_rst", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FD44, 1'b0);

    // random operands with random restarts (including on the final step
    // and in the ready cycle)
    for (int n = 0; n < 150; n++) begin
      start(pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) gap = $urandom_range(0, ITER + 1);
      else                           gap = ITER + 1 + $urandom_range(0, 3);
      idle(gap);
    end
    idle(ITER + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
